// File: rtl/field_mem_arbiter.sv
// ============================================================================
// field_mem_arbiter: shares the single-port game-field RAM between the VGA
// renderer, the game logic and a built-in field-clear sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module field_mem_arbiter #(
    parameter int                 ADDR_W     = 8,
    parameter int                 DATA_W     = 8,
    parameter int                 STARVE_LIM = 15,
    parameter logic [DATA_W-1:0]  CLR_VAL    = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [DATA_W-1:0] game_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        starve_cnt_max
);

    localparam logic [7:0] STARVE_LIM_W = 8'(STARVE_LIM);

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        CLEAR  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [7:0]        wait_q, wait_d;
    logic [7:0]        max_q, max_d;
    logic              vga_rvalid_q, game_rvalid_q;
    logic              clr_wr;
    logic              starve;

    assign starve = game_req && (wait_q == STARVE_LIM_W);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        vga_gnt   = 1'b0;
        game_gnt  = 1'b0;
        clr_wr    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Grants are forced low while reset is held so every output reads 0.
        if (!reset) begin
            case (state_q)
                NORMAL: begin
                    vga_gnt  = vga_req && !starve;
                    game_gnt = game_req && (!vga_req || starve);
                    if (clr_start) begin
                        state_d   = CLEAR;
                        clr_ptr_d = '0;
                    end
                end
                CLEAR: begin
                    vga_gnt = vga_req;
                    clr_wr  = !vga_req;
                    if (clr_wr) begin
                        clr_ptr_d = clr_ptr_q + 1'b1;
                        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                            state_d = NORMAL;
                        end
                    end
                end
                default: state_d = NORMAL;
            endcase
        end

        if (vga_gnt) begin
            mem_en   = 1'b1;
            mem_addr = vga_addr;
        end else if (game_gnt) begin
            mem_en    = 1'b1;
            mem_we    = game_we;
            mem_addr  = game_addr;
            mem_wdata = game_wdata;
        end else if (clr_wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_ptr_q;
            mem_wdata = CLR_VAL;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if ((state_q == CLEAR) || !game_req || game_gnt) begin
            wait_d = '0;
        end else if (wait_q < STARVE_LIM_W) begin
            wait_d = wait_q + 8'd1;
        end
        // An 8-bit high-water mark cannot exceed 255, so it saturates for free.
        max_d = (wait_q > max_q) ? wait_q : max_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= NORMAL;
            clr_ptr_q     <= '0;
            wait_q        <= '0;
            max_q         <= '0;
            vga_rvalid_q  <= 1'b0;
            game_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wait_q        <= wait_d;
            max_q         <= max_d;
            vga_rvalid_q  <= vga_gnt;
            game_rvalid_q <= game_gnt && !game_we;
        end
    end

    assign clr_busy       = (state_q == CLEAR);
    assign vga_rvalid     = vga_rvalid_q;
    assign game_rvalid    = game_rvalid_q;
    assign vga_rdata      = mem_rdata;
    assign game_rdata     = mem_rdata;
    assign starve_cnt_max = max_q;

endmodule

`default_nettype wire

// File: tb/tb_field_mem_arbiter.sv
// ============================================================================
// tb_field_mem_arbiter: directed and randomized checks of field_mem_arbiter
// against a cycle-level behavioural model of the arbitration rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_field_mem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LIM = 15;
    localparam int N   = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_gnt, vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          game_req = 1'b0;
    logic          game_we = 1'b0;
    logic [AW-1:0] game_addr = '0;
    logic [DW-1:0] game_wdata = '0;
    logic          game_gnt, game_rvalid;
    logic [DW-1:0] game_rdata;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [7:0]    starve_cnt_max;

    always #5 clk = ~clk;

    field_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM), .CLR_VAL(8'h00)
    ) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_gnt(game_gnt),
        .game_rvalid(game_rvalid), .game_rdata(game_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .starve_cnt_max(starve_cnt_max)
    );

    // The physical RAM the arbiter drives
    logic [DW-1:0] ram [N];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected field contents and arbitration outcome
    logic [DW-1:0] m_mem [N];
    bit m_clearing = 0;
    int m_ptr = 0, m_wait = 0, m_max = 0;
    bit m_rv_v = 0, m_rv_g = 0;
    int m_vdata = 0, m_gdata = 0;
    bit e_vg = 0, e_eg = 0, e_clrw = 0, e_starve = 0;

    always @(negedge clk) begin
        if (reset) begin
            e_vg = 0; e_eg = 0; e_clrw = 0;
            chk("rst_vga_gnt", vga_gnt, 0);
            chk("rst_game_gnt", game_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_busy", clr_busy, 0);
            chk("rst_vga_rvalid", vga_rvalid, 0);
            chk("rst_game_rvalid", game_rvalid, 0);
            chk("rst_max", starve_cnt_max, 0);
        end else begin
            if (m_clearing) begin
                e_eg = 0; e_vg = vga_req; e_clrw = !vga_req;
            end else begin
                e_starve = game_req && (m_wait == LIM);
                e_vg   = vga_req && !e_starve;
                e_eg   = game_req && (!vga_req || e_starve);
                e_clrw = 0;
            end
            chk("vga_gnt", vga_gnt, e_vg);
            chk("game_gnt", game_gnt, e_eg);
            chk("clr_busy", clr_busy, m_clearing);
            chk("mem_en", mem_en, e_vg || e_eg || e_clrw);
            chk("mem_we", mem_we, e_clrw || (e_eg && game_we));
            if (e_vg)        chk("mem_addr_vga", mem_addr, vga_addr);
            else if (e_eg)   chk("mem_addr_game", mem_addr, game_addr);
            else if (e_clrw) chk("mem_addr_clr", mem_addr, m_ptr);
            if (e_eg && game_we) chk("mem_wdata_game", mem_wdata, game_wdata);
            if (e_clrw)          chk("mem_wdata_clr", mem_wdata, 0);
            chk("starve_cnt_max", starve_cnt_max, m_max);
            chk("vga_rvalid", vga_rvalid, m_rv_v);
            chk("game_rvalid", game_rvalid, m_rv_g);
            if (m_rv_v) chk("vga_rdata", vga_rdata, m_vdata);
            if (m_rv_g) chk("game_rdata", game_rdata, m_gdata);
        end
    end

    always @(posedge clk) begin
        bit was_clearing;
        if (reset) begin
            m_clearing = 0; m_ptr = 0; m_wait = 0; m_max = 0;
            m_rv_v = 0; m_rv_g = 0;
        end else begin
            was_clearing = m_clearing;
            if (m_wait > m_max) m_max = (m_wait > 255) ? 255 : m_wait;
            m_rv_v = e_vg;
            m_rv_g = e_eg && !game_we;
            if (e_vg)   m_vdata = m_mem[vga_addr];
            if (m_rv_g) m_gdata = m_mem[game_addr];
            if (e_eg && game_we) m_mem[game_addr] = game_wdata;
            if (e_clrw) begin
                m_mem[m_ptr] = 8'h00;
                m_ptr++;
                if (m_ptr == N) begin
                    m_clearing = 0;
                    m_ptr = 0;
                end
            end
            if (was_clearing || !game_req || e_eg) m_wait = 0;
            else m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
            if (!was_clearing && clr_start) begin
                m_clearing = 1;
                m_ptr = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int first, vg_first, vg_next, busy, gnt_clr, vgnt;
        bit gs, vs;
        logic [7:0] rnd;

        for (int i = 0; i < N; i++) begin
            rnd = 8'($urandom);
            ram[i] = rnd;
            m_mem[i] = rnd;
        end

        repeat (3) tick();
        chk("init_busy", clr_busy, 0);
        chk("init_max", starve_cnt_max, 0);
        reset = 1'b0;
        tick();

        // Game write then read-back of the same cell
        game_req = 1; game_we = 1; game_addr = 8'h21; game_wdata = 8'h5A;
        #1;
        chk("s1_wr_gnt", game_gnt, 1);
        chk("s1_mem_we", mem_we, 1);
        tick();
        game_we = 0;
        #1;
        chk("s1_rd_gnt", game_gnt, 1);
        tick();
        game_req = 0;
        #1;
        chk("s1_rvalid", game_rvalid, 1);
        chk("s1_rdata", game_rdata, 8'h5A);
        tick();

        // Continuous VGA traffic against a waiting game read
        vga_req = 1; vga_addr = 8'($urandom);
        game_req = 1; game_we = 0; game_addr = 8'h21;
        first = -1; vg_first = -1; vg_next = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            gs = game_gnt; vs = vga_gnt;
            if (gs && first < 0) begin first = k; vg_first = vs; end
            if (first >= 0 && k == first + 1) vg_next = vs;
            tick();
            if (gs) game_req = 0;
            if (vs) vga_addr = 8'($urandom);
        end
        chk("s2_first_game_gnt", first, 15);
        chk("s2_vga_gnt_at_starve", vg_first, 0);
        chk("s2_vga_gnt_after", vg_next, 1);
        vga_req = 0;
        tick();
        chk("s2_max", starve_cnt_max, 15);

        // Clear with VGA idle; game waits; re-pulse at pointer 50 is ignored
        clr_start = 1;
        tick();
        clr_start = 0;
        game_req = 1; game_we = 0; game_addr = 8'h33;
        busy = 0; gnt_clr = 0;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (!clr_busy) break;
            busy++;
            if (game_gnt) gnt_clr++;
            if (busy == 51) clr_start = 1;
            tick();
            clr_start = 0;
        end
        chk("s3_busy_len", busy, 256);
        chk("s3_game_gnt_in_clear", gnt_clr, 0);
        chk("s3_game_gnt_after", game_gnt, 1);
        tick();
        for (int a = 0; a <= N; a++) begin
            if (a < N) begin game_req = 1; game_addr = 8'(a); end
            else game_req = 0;
            #1;
            if (a > 0) begin
                chk("s3_readback_rvalid", game_rvalid, 1);
                chk("s3_readback_zero", game_rdata, 0);
            end
            tick();
        end

        // Clear with VGA requesting every other cycle
        clr_start = 1;
        tick();
        clr_start = 0;
        vga_req = 1; vga_addr = 8'($urandom);
        busy = 0; vgnt = 0;
        for (int k = 0; k < 700; k++) begin
            #1;
            if (!clr_busy) break;
            busy++;
            if (vga_gnt) vgnt++;
            tick();
            vga_req = !vga_req;
            vga_addr = 8'($urandom);
        end
        chk("s4_busy_len", busy, 512);
        chk("s4_vga_gnts", vgnt, 256);
        vga_req = 0;
        tick();

        // Reset in the middle of a clear, with a VGA read outstanding
        game_req = 1; game_we = 1; game_addr = 8'd200; game_wdata = 8'hA7;
        tick();
        game_req = 0;
        clr_start = 1;
        tick();
        clr_start = 0;
        repeat (100) tick();
        vga_req = 1; vga_addr = 8'd5;
        tick();
        reset = 1; vga_req = 0;
        #1;
        chk("s5_vga_gnt", vga_gnt, 0);
        chk("s5_game_gnt", game_gnt, 0);
        chk("s5_vga_rvalid", vga_rvalid, 0);
        chk("s5_game_rvalid", game_rvalid, 0);
        chk("s5_busy", clr_busy, 0);
        chk("s5_mem_en", mem_en, 0);
        chk("s5_mem_we", mem_we, 0);
        chk("s5_mem_addr", mem_addr, 0);
        chk("s5_mem_wdata", mem_wdata, 0);
        chk("s5_max", starve_cnt_max, 0);
        repeat (3) tick();
        reset = 0;
        #1;
        chk("s5_busy_after", clr_busy, 0);
        game_req = 1; game_we = 0; game_addr = 8'd200;
        #1;
        chk("s5_rd_gnt", game_gnt, 1);
        tick();
        game_req = 0;
        #1;
        chk("s5_rvalid", game_rvalid, 1);
        chk("s5_rdata_kept", game_rdata, 8'hA7);
        tick();

        // Randomized traffic; the per-cycle model comparison does the checking
        for (int k = 0; k < 3000; k++) begin
            #1;
            vs = vga_gnt; gs = game_gnt;
            tick();
            reset = 0;
            clr_start = ($urandom_range(0, 399) == 0);
            if (vga_req && !vs && $urandom_range(0, 15) != 0) begin
                // hold pending request
            end else begin
                vga_req  = ($urandom_range(0, 1) == 0);
                vga_addr = 8'($urandom);
            end
            if (game_req && !gs && $urandom_range(0, 15) != 0) begin
                // hold pending request
            end else begin
                game_req   = ($urandom_range(0, 4) < 3);
                game_we    = ($urandom_range(0, 2) == 0);
                game_addr  = 8'($urandom_range(0, 15));
                game_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 999) == 0) reset = 1;
        end
        reset = 0; vga_req = 0; game_req = 0; clr_start = 0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/field_mem_arbiter.md
Name: field_mem_arbiter

Overview:
- Shares the single-port, synchronous-read game-field RAM between three users: the VGA tile renderer (read-only), the game logic (read/write), and a built-in field-clear sequencer.
- Sits inside ctrl_main_block between the keyboard-driven game FSM, the VGA pixel pipeline and the field RAM.
- Fixed priority with a starvation override for the game port.

Parameters:
- ADDR_W, 8, field RAM address width (16x16 cells).
- DATA_W, 8, cell word width.
- STARVE_LIM, 15, consecutive waiting cycles after which the game port wins one slot.
- CLR_VAL, 8'h00, word written to every cell by the clear sequencer.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vga_req  in  1  renderer read request; held with stable vga_addr until vga_gnt
- vga_addr  in  ADDR_W  renderer read address
- vga_gnt  out  1  renderer request issued to RAM this cycle
- vga_rvalid  out  1  vga_rdata valid (1 cycle after vga_gnt)
- vga_rdata  out  DATA_W  read data (passthrough of mem_rdata)
- game_req  in  1  game request; held with stable addr/we/wdata until game_gnt
- game_we  in  1  1 = write, 0 = read
- game_addr  in  ADDR_W  game address
- game_wdata  in  DATA_W  game write data
- game_gnt  out  1  game request issued this cycle
- game_rvalid  out  1  game_rdata valid (1 cycle after a read grant)
- game_rdata  out  DATA_W  read data (passthrough of mem_rdata)
- clr_start  in  1  pulse: clear the whole field
- clr_busy  out  1  clear sequence in progress
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we = 0
- starve_cnt_max  out  8  saturating high-water mark of the game wait counter (debug/leds)

Behaviour:
- Reset values: all outputs 0; FSM = NORMAL; clear pointer 0; wait counter 0.
- One RAM access per cycle at most. Grant outputs are combinational from the current requests and state. mem_* are driven combinationally from the granted requester.
- FSM states:
  - NORMAL, priority VGA > game. If game_req is pending and the wait counter equals STARVE_LIM, the game wins the cycle and VGA waits.
  - CLEAR, priority VGA > clear engine. Each free slot writes CLR_VAL to the clear pointer and increments it. After address 2^ADDR_W-1 is written, the FSM returns to NORMAL on the next cycle.
- CLEAR rules:
  - game_gnt is forced to 0.
  - The wait counter is held at 0.
  - The starvation override is disabled, so VGA is never blocked during CLEAR.
- Wait counter: increments each cycle game_req = 1 and game_gnt = 0. It resets to 0 on game_gnt or when game_req = 0, and saturates at STARVE_LIM.
- starve_cnt_max: updated to the wait counter value whenever that value is larger; it saturates at 255.
- clr_start:
  - In NORMAL it enters CLEAR the next cycle, with the pointer at 0 and clr_busy = 1 from that cycle.
  - A game grant issued in the same cycle as clr_start completes normally.
  - clr_start while in CLEAR is ignored; the pointer does not restart.
- rvalid: vga_rvalid and game_rvalid are registered copies of read grants. vga_rdata and game_rdata equal mem_rdata every cycle and are meaningful only when the matching rvalid is 1.
- Writes never raise rvalid. A game write followed by a read of the same address on the next grant returns the new data.
- Requests dropped before grant are legal; the arbiter keeps no state for them.
- Reset mid-clear: the clear is abandoned, the FSM returns to NORMAL and clr_busy = 0. Partially cleared memory is left as is.
- Reset while a read is outstanding: the rvalid for that read is suppressed.

Test Plan:
- Game write addr 8'h21 data 8'h5A with VGA idle -> game_gnt same cycle, mem_we = 1. A following game read of 8'h21 -> game_rvalid 1 cycle after grant, game_rdata = 8'h5A.
- VGA and game both requesting from cycle 0, VGA continuous -> game_gnt first at cycle 15 (STARVE_LIM). vga_gnt = 0 that cycle and 1 on cycle 16. starve_cnt_max = 15.
- clr_start with VGA idle -> clr_busy for exactly 256 cycles, then 1 cycle to NORMAL. All 256 cells read back 8'h00. game_req during clear -> game_gnt stays 0 until clr_busy = 0.
- clr_start with vga_req asserted every other cycle -> clear takes 512 cycles. VGA is never delayed: vga_gnt each request cycle, vga_rvalid 1 cycle later.
- Reset asserted at clear pointer 100 -> all outputs 0 immediately. After release, clr_busy = 0, and a game read of address 200 returns its pre-clear contents.
- clr_start pulsed again at pointer 50 -> ignored. Total clear duration unchanged at 256 cycles with VGA idle.
